// File: rtl/morse_game_ctrl.sv
// Morse code practice game sequencer: walks a word ROM, scores each submitted
// code against the expected one, and reports game-over / win.
module morse_game_ctrl #(
    parameter int NUM_WORDS = 8,
    parameter int ADDR_W    = 4,
    parameter int WIN_SCORE = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              entry_done,
    input  logic [7:0]        entry_code,
    input  logic [7:0]        rom_data,
    input  logic              TimeOut,
    output logic              enable,
    output logic              reconfig,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        score,
    output logic              game_over,
    output logic              win
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [4:0]        WIN_TH    = 5'(WIN_SCORE);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        score_q, score_d;
    logic              match_q, match_d;
    logic              enable_q, reconfig_q, game_over_q, win_q;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        score_d = score_q;
        match_d = match_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    score_d = '0;
                end
            end
            S_LOAD:  state_d = S_FETCH;
            S_FETCH: state_d = S_PLAY;
            S_PLAY: begin
                // An expired timer wins over an answer arriving in the same cycle.
                if (TimeOut) begin
                    state_d = S_DONE;
                end else if (entry_done) begin
                    match_d = (entry_code == rom_data);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (match_q) begin
                    score_d = sat_inc(score_q);
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            score_q     <= '0;
            enable_q    <= 1'b0;
            reconfig_q  <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            score_q     <= score_d;
            enable_q    <= (state_d == S_FETCH) || (state_d == S_PLAY) || (state_d == S_CHECK);
            reconfig_q  <= (state_d == S_LOAD);
            game_over_q <= (state_d == S_DONE);
            win_q       <= (state_d == S_DONE) && ({1'b0, score_d} >= WIN_TH);
        end
    end

    always_ff @(posedge clk) begin
        match_q <= match_d;
    end

    assign enable    = enable_q;
    assign reconfig  = reconfig_q;
    assign rom_addr  = addr_q;
    assign score     = score_q;
    assign game_over = game_over_q;
    assign win       = win_q;

endmodule

// File: tb/tb_morse_game_ctrl.sv
// Bench for morse_game_ctrl: directed game scenarios plus randomized games,
// scored against a word-count model of the game rules.
module tb_morse_game_ctrl;

    localparam int NW = 8;
    localparam int AW = 4;
    localparam int WS = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          entry_done;
    logic [7:0]    entry_code;
    logic [7:0]    rom_data;
    logic          TimeOut;
    logic          enable;
    logic          reconfig;
    logic [AW-1:0] rom_addr;
    logic [3:0]    score;
    logic          game_over;
    logic          win;

    logic [7:0] rom [0:15];
    int n_checks = 0;
    int n_errors = 0;
    int m_score;
    int m_addr;

    morse_game_ctrl #(.NUM_WORDS(NW), .ADDR_W(AW), .WIN_SCORE(WS)) dut (
        .clk(clk), .rst(rst), .start(start), .entry_done(entry_done),
        .entry_code(entry_code), .rom_data(rom_data), .TimeOut(TimeOut),
        .enable(enable), .reconfig(reconfig), .rom_addr(rom_addr),
        .score(score), .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".enable"}, 32'(enable), 0);
        check_val({tag, ".reconfig"}, 32'(reconfig), 0);
        check_val({tag, ".rom_addr"}, 32'(rom_addr), 0);
        check_val({tag, ".score"}, 32'(score), 0);
        check_val({tag, ".game_over"}, 32'(game_over), 0);
        check_val({tag, ".win"}, 32'(win), 0);
    endtask

    task automatic check_done(input string tag);
        check_val({tag, ".game_over"}, 32'(game_over), 1);
        check_val({tag, ".enable"}, 32'(enable), 0);
        check_val({tag, ".score"}, 32'(score), 32'(m_score));
        check_val({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_addr));
        check_val({tag, ".win"}, 32'(win), 32'(m_score >= WS));
    endtask

    // Leaves the DUT in its first PLAY cycle.
    task automatic start_game();
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_score = 0;
        m_addr  = 0;
        check_val("start.reconfig", 32'(reconfig), 1);
        check_val("start.enable", 32'(enable), 0);
        check_val("start.rom_addr", 32'(rom_addr), 0);
        check_val("start.score", 32'(score), 0);
        check_val("start.game_over", 32'(game_over), 0);
        check_val("start.win", 32'(win), 0);
        cyc();
        check_val("fetch.reconfig", 32'(reconfig), 0);
        check_val("fetch.enable", 32'(enable), 1);
        cyc();
        check_val("play.enable", 32'(enable), 1);
        check_val("play.reconfig", 32'(reconfig), 0);
    endtask

    // One answer from PLAY; returns with DUT in PLAY again unless the game ended.
    task automatic play_entry(input bit correct, input int waits, input bit noise,
                              input bit to_chk, output bit ended);
        ended = 1'b0;
        repeat (waits) begin
            cyc();
            check_val("wait.enable", 32'(enable), 1);
            check_val("wait.game_over", 32'(game_over), 0);
            check_val("wait.score", 32'(score), 32'(m_score));
        end
        entry_code = correct ? rom[m_addr] : (rom[m_addr] ^ 8'($urandom_range(1, 255)));
        entry_done = 1'b1;
        cyc();
        entry_done = 1'b0;
        entry_code = 8'($urandom);
        check_val("check.enable", 32'(enable), 1);
        check_val("check.score", 32'(score), 32'(m_score));
        check_val("check.rom_addr", 32'(rom_addr), 32'(m_addr));
        if (noise) begin
            start      = 1'b1;
            entry_done = 1'b1;
            entry_code = rom[m_addr];
        end
        if (to_chk) TimeOut = 1'b1;
        cyc();
        start      = 1'b0;
        entry_done = 1'b0;
        if (correct && m_score < 15) m_score++;
        check_val("post_check.score", 32'(score), 32'(m_score));
        check_val("post_check.reconfig", 32'(reconfig), 0);
        if (m_addr == NW - 1) begin
            TimeOut = 1'b0;
            check_done("last_word");
            ended = 1'b1;
            return;
        end
        m_addr++;
        check_val("fetch2.rom_addr", 32'(rom_addr), 32'(m_addr));
        check_val("fetch2.enable", 32'(enable), 1);
        check_val("fetch2.game_over", 32'(game_over), 0);
        if (noise) begin
            start      = 1'b1;
            entry_done = 1'b1;
            entry_code = rom[m_addr];
        end
        cyc();
        start      = 1'b0;
        entry_done = 1'b0;
        check_val("play2.enable", 32'(enable), 1);
        check_val("play2.reconfig", 32'(reconfig), 0);
        check_val("play2.score", 32'(score), 32'(m_score));
        check_val("play2.rom_addr", 32'(rom_addr), 32'(m_addr));
        if (to_chk) begin
            cyc();
            TimeOut = 1'b0;
            check_done("late_timeout");
            ended = 1'b1;
        end
    endtask

    task automatic timeout_play(input bit with_entry);
        TimeOut = 1'b1;
        if (with_entry) begin
            entry_done = 1'b1;
            entry_code = rom[m_addr];
        end
        cyc();
        TimeOut    = 1'b0;
        entry_done = 1'b0;
        check_done("timeout");
        cyc();
        check_done("timeout_hold");
    endtask

    initial begin
        bit ended;
        bit pat [0:7];
        rst        = 1'b0;
        start      = 1'b0;
        entry_done = 1'b0;
        entry_code = 8'h00;
        TimeOut    = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        #1;
        check_idle("reset");
        repeat (2) cyc();
        rst = 1'b1;
        repeat (3) cyc();
        check_idle("idle_after_reset");

        // All words answered correctly.
        start_game();
        for (int i = 0; i < NW; i++) play_entry(1'b1, 0, 1'b0, 1'b0, ended);
        check_val("all_match.score", 32'(score), 8);
        check_val("all_match.rom_addr", 32'(rom_addr), 7);
        check_val("all_match.win", 32'(win), 1);

        // Three right, then timer expires alongside an answer.
        start_game();
        for (int i = 0; i < 3; i++) play_entry(1'b1, 1, 1'b0, 1'b0, ended);
        timeout_play(1'b1);
        check_val("timeout3.score", 32'(score), 3);
        check_val("timeout3.win", 32'(win), 0);

        // Five wrong, three right.
        start_game();
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < NW; i++) play_entry(pat[i], 0, 1'b0, 1'b0, ended);
        check_val("mixed.score", 32'(score), 3);
        check_val("mixed.rom_addr", 32'(rom_addr), 7);
        check_val("mixed.win", 32'(win), 0);

        // Exactly the win threshold, with stray pulses in FETCH/CHECK.
        start_game();
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < NW; i++) play_entry(pat[i], 0, 1'b1, 1'b0, ended);
        check_val("threshold.win", 32'(win), 1);

        // Reset mid-game at word 4 with score 2.
        start_game();
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) play_entry(pat[i], 0, 1'b0, 1'b0, ended);
        check_val("pre_rst.rom_addr", 32'(rom_addr), 4);
        check_val("pre_rst.score", 32'(score), 2);
        #3;
        rst = 1'b0;
        #1;
        check_idle("async_rst");
        cyc();
        #4;
        rst = 1'b1;
        repeat (4) begin
            cyc();
            check_idle("idle_hold");
        end

        // Randomized games.
        for (int g = 0; g < 25; g++) begin
            int k;
            start_game();
            k = $urandom_range(0, NW);
            for (int i = 0; i < NW; i++) begin
                if (i == k) begin
                    timeout_play(1'($urandom));
                    break;
                end
                play_entry(1'($urandom), $urandom_range(0, 2), 1'($urandom),
                           ($urandom_range(0, 7) == 0), ended);
                if (ended) break;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
